// File: rtl/affine_interp_6tap_pipe_pkg.sv
// Shared constants and helpers for the 6-tap affine interpolation filter.
package affine_interp_pkg;

    localparam int NUM_TAPS      = 6;
    localparam int FRAC_BITS     = 4;
    localparam int COEF_SUM_LOG2 = 6;

    // Coefficient c<tap> for a 1/16 phase; every row sums to 64.
    function automatic int coef(input int tap, input int frac);
        int row [NUM_TAPS];
        case (frac)
            0:       row = '{0,   0, 64,  0,   0, 0};
            1:       row = '{1,  -3, 63,  4,  -2, 1};
            2:       row = '{1,  -5, 62,  8,  -3, 1};
            3:       row = '{2,  -8, 60, 13,  -4, 1};
            4:       row = '{3, -10, 58, 17,  -5, 1};
            5:       row = '{3, -11, 52, 26,  -8, 2};
            6:       row = '{2,  -9, 47, 31, -10, 3};
            7:       row = '{3, -11, 45, 34, -10, 3};
            8:       row = '{3, -11, 40, 40, -11, 3};
            9:       row = '{3, -10, 34, 45, -11, 3};
            10:      row = '{3, -10, 31, 47,  -9, 2};
            11:      row = '{2,  -8, 26, 52, -11, 3};
            12:      row = '{1,  -5, 17, 58, -10, 3};
            13:      row = '{1,  -4, 13, 60,  -8, 2};
            14:      row = '{1,  -3,  8, 62,  -5, 1};
            15:      row = '{1,  -2,  4, 63,  -3, 1};
            default: row = '{0,   0,  0,  0,   0, 0};
        endcase
        return row[3'(tap)];
    endfunction

    // Full-precision accumulator width for a given signed input width.
    function automatic int out_width(input int in_size);
        return in_size + COEF_SUM_LOG2 + 1;
    endfunction

endpackage

// File: rtl/affine_interp_6tap_pipe_if.sv
// Sample-in / result-out stream bundle for the interpolation filter.
interface affine_interp_6tap_pipe_if #(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = 15
);
    import affine_interp_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_SIZE-1:0]   in_sample;
    logic [FRAC_BITS-1:0]        in_frac;
    logic                        in_sol;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_SIZE-1:0]  out_data;

    modport slave (
        input  in_valid, in_sample, in_frac, in_sol, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_sample, in_frac, in_sol, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/affine_interp_6tap_pipe_mcm.sv
// Constant-coefficient shift/add product for one tap across all 16 phases.
module affine_tap_mcm
    import affine_interp_pkg::*;
#(
    parameter int TAP     = 0,
    parameter int IN_SIZE = 8
) (
    input  logic signed [IN_SIZE-1:0]  x_i,
    input  logic [FRAC_BITS-1:0]       frac_i,
    output logic signed [IN_SIZE+6:0]  prod_o
);

    localparam int PW = IN_SIZE + 7;

    // Sum of shifted copies of x for each set bit of |c|; c is an
    // elaboration-time constant so this folds to a fixed adder chain.
    function automatic logic signed [PW-1:0] shift_add(
        input logic signed [IN_SIZE-1:0] x,
        input int                        c
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] acc;
        logic [COEF_SUM_LOG2:0] mag;
        xe  = PW'(x);
        acc = '0;
        mag = (COEF_SUM_LOG2 + 1)'((c < 0) ? -c : c);
        for (int k = 0; k <= COEF_SUM_LOG2; k++) begin
            if (mag[3'(k)]) acc = acc + (xe <<< k);
        end
        return (c < 0) ? -acc : acc;
    endfunction

    logic signed [PW-1:0] cand [16];

    for (genvar f = 0; f < 16; f++) begin : g_phase
        localparam int C = coef(TAP, f);
        assign cand[f] = shift_add(x_i, C);
    end

    assign prod_o = cand[frac_i];

endmodule

// File: rtl/affine_interp_6tap_pipe.sv
// Streaming 6-tap 1/16-phase luma interpolation filter: window, S1 products, S2 sum.
module affine_interp_6tap_pipe
    import affine_interp_pkg::*;
#(
    parameter int IN_SIZE     = 8,
    parameter int ROUND_SHIFT = 0,
    parameter int OUT_SIZE    = out_width(IN_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    affine_interp_6tap_pipe_if.slave  bus
);

    localparam int PW = IN_SIZE + 7;
    // One spare bit so the rounding offset can never wrap the sum.
    localparam int SW = PW + 1;

    logic                       en;
    logic                       accept;
    logic signed [IN_SIZE-1:0]  win_q [NUM_TAPS];
    logic signed [IN_SIZE-1:0]  win_d [NUM_TAPS];
    logic [2:0]                 fill_q;
    logic [2:0]                 fill_d;
    logic                       s1_valid_q;
    logic                       s1_valid_d;
    logic signed [PW-1:0]       prod_q [NUM_TAPS];
    logic signed [PW-1:0]       prod_d [NUM_TAPS];
    logic signed [SW-1:0]       sum_c;
    logic signed [SW-1:0]       rnd_c;
    logic                       out_valid_q;
    logic signed [OUT_SIZE-1:0] out_data_q;
    logic signed [OUT_SIZE-1:0] out_data_d;

    // A stalled output freezes the whole pipe, so one enable serves every stage.
    assign en     = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && en;

    // Next window/fill: shift in on accept; sol restarts the fill count at this sample.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (accept) begin
            for (int i = 0; i < NUM_TAPS - 1; i++) win_d[i] = win_q[i+1];
            win_d[NUM_TAPS-1] = bus.in_sample;
            if (bus.in_sol)
                fill_d = 3'd1;
            else if (fill_q < 3'(NUM_TAPS))
                fill_d = fill_q + 3'd1;
        end
        s1_valid_d = accept && (fill_d == 3'(NUM_TAPS));
    end

    // Products come from the post-shift window so the newest sample is tap 5.
    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        affine_tap_mcm #(.TAP(t), .IN_SIZE(IN_SIZE)) u_mcm (
            .x_i    (win_d[t]),
            .frac_i (bus.in_frac),
            .prod_o (prod_d[t])
        );
    end

    // Adder tree over the registered products.
    always_comb begin
        sum_c = '0;
        for (int t = 0; t < NUM_TAPS; t++) sum_c = sum_c + SW'(prod_q[t]);
    end

    if (ROUND_SHIFT > 0) begin : g_round
        localparam logic signed [SW-1:0] HALF = SW'(64'd1 << (ROUND_SHIFT - 1));
        assign rnd_c = (sum_c + HALF) >>> ROUND_SHIFT;
    end else begin : g_full
        assign rnd_c = sum_c;
    end

    assign out_data_d = OUT_SIZE'(rnd_c);

    // Window register and fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

    // S1: tap products and token valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int t = 0; t < NUM_TAPS; t++) prod_q[t] <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
        end
    end

    // S2: normalised sum, drives the output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_affine_interp_6tap_pipe.sv
// Bench for affine_interp_6tap_pipe: vector table, corner sequences, random stream vs model.
module tb_affine_interp_6tap_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    affine_interp_6tap_pipe_if #(.IN_SIZE(8), .OUT_SIZE(15)) if0 ();
    affine_interp_6tap_pipe_if #(.IN_SIZE(8), .OUT_SIZE(15)) if6 ();

    assign if6.in_valid  = if0.in_valid;
    assign if6.in_sample = if0.in_sample;
    assign if6.in_frac   = if0.in_frac;
    assign if6.in_sol    = if0.in_sol;
    assign if6.out_ready = if0.out_ready;

    affine_interp_6tap_pipe #(.IN_SIZE(8), .ROUND_SHIFT(0), .OUT_SIZE(15)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    affine_interp_6tap_pipe #(.IN_SIZE(8), .ROUND_SHIFT(6), .OUT_SIZE(15)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(if6));

    int COEF [16][6] = '{
        '{0,   0, 64,  0,   0, 0}, '{1,  -3, 63,  4,  -2, 1},
        '{1,  -5, 62,  8,  -3, 1}, '{2,  -8, 60, 13,  -4, 1},
        '{3, -10, 58, 17,  -5, 1}, '{3, -11, 52, 26,  -8, 2},
        '{2,  -9, 47, 31, -10, 3}, '{3, -11, 45, 34, -10, 3},
        '{3, -11, 40, 40, -11, 3}, '{3, -10, 34, 45, -11, 3},
        '{3, -10, 31, 47,  -9, 2}, '{2,  -8, 26, 52, -11, 3},
        '{1,  -5, 17, 58, -10, 3}, '{1,  -4, 13, 60,  -8, 2},
        '{1,  -3,  8, 62,  -5, 1}, '{1,  -2,  4, 63,  -3, 1}};

    typedef struct {
        int x;
        int frac;
        bit sol;
        bit has_out;
        int exp;
    } vec_t;

    vec_t tbl[$];
    int   tbl_q[$];
    int   hist[$];
    int   exp0_q[$];
    int   exp6_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   out_cnt = 0;
    bit   prev_stall = 0;
    int   prev_data = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
            exp0_q.delete();
            exp6_q.delete();
            tbl_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(if0.out_valid), 1);
                check("hold_data", int'(if0.out_data), prev_data);
            end
            if (if0.out_valid && !if0.out_ready)
                check("stall_in_ready", int'(if0.in_ready), 0);
            if (if0.out_valid && if0.out_ready) begin
                out_cnt++;
                if (exp0_q.size() == 0) check("unexpected_out_rs0", int'(if0.out_data), 99999);
                else check("model_rs0", int'(if0.out_data), exp0_q.pop_front());
                if (tbl_q.size() > 0) check("table", int'(if0.out_data), tbl_q.pop_front());
            end
            if (if6.out_valid && if6.out_ready) begin
                if (exp6_q.size() == 0) check("unexpected_out_rs6", int'(if6.out_data), 99999);
                else check("model_rs6", int'(if6.out_data), exp6_q.pop_front());
            end
            if (if0.in_valid && if0.in_ready) begin
                int acc;
                int f;
                if (if0.in_sol) hist.delete();
                hist.push_back(int'(if0.in_sample));
                if (hist.size() > 6) void'(hist.pop_front());
                if (hist.size() == 6) begin
                    f = int'(if0.in_frac);
                    acc = 0;
                    for (int k = 0; k < 6; k++) acc += COEF[f][k] * hist[k];
                    exp0_q.push_back(acc);
                    exp6_q.push_back((acc + 32) >>> 6);
                end
            end
            prev_stall = if0.out_valid && !if0.out_ready;
            prev_data  = int'(if0.out_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic feed(input int x, input int f, input bit sol);
        int waited;
        waited = 0;
        if0.in_valid  = 1'b1;
        if0.in_sample = 8'(x);
        if0.in_frac   = 4'(f);
        if0.in_sol    = sol;
        @(negedge clk);
        while (!if0.in_ready && waited < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 50) begin
            n_fail++;
            $display("FAIL feed_timeout: waited %0d cycles, expected acceptance", waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if0.in_valid = 1'b0;
        if0.in_sol   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            if0.in_valid  = ($urandom_range(0, 99) < 75);
            if0.in_sample = 8'($urandom);
            if0.in_frac   = 4'($urandom);
            if0.in_sol    = ($urandom_range(0, 99) < 3);
            if0.out_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk); #1;
        end
        if0.in_valid  = 1'b0;
        if0.in_sol    = 1'b0;
        if0.out_ready = 1'b1;
    endtask

    initial begin
        int imp [12];
        int imp_exp [12];
        int ext [6];
        int cnt0;
        int held;

        if0.in_valid  = 1'b0;
        if0.in_sample = '0;
        if0.in_frac   = '0;
        if0.in_sol    = 1'b0;
        if0.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(if0.out_valid), 0);
        check("reset_out_data", int'(if0.out_data), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_in_ready", int'(if0.in_ready), 1);

        // Vector table: constant, impulse, extremes
        for (int i = 0; i < 21; i++)
            tbl.push_back('{x: 100, frac: i % 16, sol: (i == 0), has_out: (i >= 5), exp: 6400});
        imp     = '{0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0};
        imp_exp = '{0, 0, 0, 0, 0, 300, -1100, 4000, 4000, -1100, 300, 0};
        for (int i = 0; i < 12; i++)
            tbl.push_back('{x: imp[i], frac: 8, sol: (i == 0), has_out: (i >= 5), exp: imp_exp[i]});
        ext = '{127, -128, 127, 127, -128, 127};
        for (int i = 0; i < 6; i++)
            tbl.push_back('{x: ext[i], frac: 8, sol: (i == 0), has_out: (i == 5), exp: 13738});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{x: (ext[i] == 127) ? -128 : 127, frac: 8, sol: (i == 0),
                            has_out: (i == 5), exp: -13802});

        foreach (tbl[i]) begin
            feed(tbl[i].x, tbl[i].frac, tbl[i].sol);
            if (tbl[i].has_out) tbl_q.push_back(tbl[i].exp);
        end
        idle(6);
        check("table_drained", tbl_q.size(), 0);

        // Latency: first token visible exactly two cycles after the 6th accept
        feed(0, 8, 1'b1);
        for (int i = 0; i < 4; i++) feed(0, 8, 1'b0);
        feed(100, 8, 1'b0);
        if0.in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_early", int'(if0.out_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_valid", int'(if0.out_valid), 1);
        check("lat_data", int'(if0.out_data), 300);
        @(posedge clk); #1;
        idle(4);

        // Start of line mid-stream: in-flight tokens finish, then 5 silent samples
        cnt0 = out_cnt;
        feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < 7; i++) feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
        feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < 4; i++) feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
        idle(6);
        check("sol_outputs", out_cnt - cnt0, 3);
        feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
        idle(4);
        check("sol_resume", out_cnt - cnt0, 4);

        // Backpressure: 3-cycle stall in a dense stream
        for (int c = 0; c < 30; c++) begin
            if0.in_valid  = 1'b1;
            if0.in_sample = 8'($urandom);
            if0.in_frac   = 4'($urandom);
            if0.in_sol    = (c == 0);
            if0.out_ready = !(c >= 12 && c < 15);
            if (c == 12) begin
                @(negedge clk);
                check("bp_valid_at_stall", int'(if0.out_valid), 1);
                held = int'(if0.out_data);
                @(posedge clk); #1;
            end else if (c == 14) begin
                @(negedge clk);
                check("bp_data_held", int'(if0.out_data), held);
                check("bp_in_ready_low", int'(if0.in_ready), 0);
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if0.out_ready = 1'b1;
        idle(6);
        check("bp_drained_rs0", exp0_q.size(), 0);
        check("bp_drained_rs6", exp6_q.size(), 0);

        // Asynchronous reset mid-stream
        feed(int'($urandom_range(0, 255)), 3, 1'b1);
        for (int i = 0; i < 7; i++) feed(int'($urandom_range(0, 255)), 5, 1'b0);
        check("pre_reset_valid", int'(if0.out_valid), 1);
        if0.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(if0.out_valid), 0);
        check("rst_out_data", int'(if0.out_data), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(if0.in_ready), 1);
        cnt0 = out_cnt;
        for (int i = 0; i < 5; i++) feed(int'($urandom_range(0, 255)), 7, 1'b0);
        idle(4);
        check("rst_priming", out_cnt - cnt0, 0);
        feed(int'($urandom_range(0, 255)), 7, 1'b0);
        idle(4);
        check("rst_first_out", out_cnt - cnt0, 1);

        // Random traffic against the model
        run_random(3000);
        idle(8);
        check("final_drained_rs0", exp0_q.size(), 0);
        check("final_drained_rs6", exp6_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
